diff_writeback: RTL and testbench

- Writeback stage directly downstream of the ALU's diff unit.
- Takes the diff result (6-bit lowest-differing-bit index plus equality flag) and the destination register index, and buffers them in a 2-entry skid FIFO.
- Converts each result to a 32-bit register-file write and updates the processor zero flag.
- Also exposes a bypass view of the oldest pending result for hazard forwarding in the execute stage.

---
 rtl/diff_writeback_if.sv | 27 ++
 rtl/diff_writeback.sv | 147 ++++++++++++++
 tb/tb_diff_writeback.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/diff_writeback_if.sv
// Handshake bundle between the diff unit, the writeback stage and the
// register-file write port. The slave side is the writeback stage; the
// master side is whatever sits around it: the diff unit and the register file.
interface diff_writeback_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_diff;
  logic              in_eq;
  logic [ADDR_W-1:0] in_rd;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, in_diff, in_eq, in_rd, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_diff, in_eq, in_rd, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/diff_writeback.sv
// Writeback stage behind the ALU diff unit. Results are converted to 32-bit
// register-file writes at push time and buffered in a 2-entry skid FIFO made
// of an explicit head register and a second (tail) register. The head
// register only changes when a new entry moves into it, so wr_addr/wr_data
// keep their last values while the FIFO is empty. Entries addressed to r0
// retire in one cycle without a write.
module diff_writeback #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  diff_writeback_if.slave   bus,
  output logic              zf,
  output logic              byp_valid,
  output logic [ADDR_W-1:0] byp_addr,
  output logic [31:0]       byp_data,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              in_ready_q;

  logic [ADDR_W-1:0] hd_rd,   tl_rd;
  logic [31:0]       hd_data, tl_data;
  logic              hd_eq,   tl_eq;

  logic              push, pop, hd_live;
  logic              load_hd_in, load_hd_tl, load_tl;
  logic [31:0]       conv_data;

  assign push    = bus.in_valid & in_ready_q;
  assign hd_live = (state != EMPTY);
  // An r0 head pops unconditionally; any other head pops when the port accepts.
  assign pop     = hd_live & ((hd_rd == '0) | bus.wr_ready);

  assign bus.in_ready = in_ready_q;
  assign bus.wr_valid = hd_live & (hd_rd != '0);
  assign bus.wr_addr  = hd_rd;
  assign bus.wr_data  = hd_data;

  assign byp_valid = bus.wr_valid;
  assign byp_addr  = hd_rd;
  assign byp_data  = hd_data;

  // Convert the incoming diff result to register write data (saturate 32..63).
  always_comb begin
    if (bus.in_eq)
      conv_data = 32'hFFFF_FFFF;
    else if (bus.in_diff[5])
      conv_data = 32'd31;
    else
      conv_data = {26'b0, bus.in_diff};
  end

  // Next occupancy and which register loads from where.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    state_nx   = state;
    load_hd_in = 1'b0;
    load_hd_tl = 1'b0;
    load_tl    = 1'b0;
    unique case (state)
      EMPTY: if (push) begin
        state_nx   = ONE;
        load_hd_in = 1'b1;
      end
      ONE: begin
        if (push && pop) begin
          load_hd_in = 1'b1;
        end else if (push) begin
          state_nx = TWO;
          load_tl  = 1'b1;
        end else if (pop) begin
          state_nx = EMPTY;
        end
      end
      TWO: if (pop) begin
        state_nx   = ONE;
        load_hd_tl = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Occupancy register; in_ready is a flop so wr_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != TWO);
    end
  end

  // Head and tail entry registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the entry registers are reset on purpose: the head drives
    // wr_addr/wr_data, which must read zero after reset. They are two small
    // registers, not a RAM, so the reset costs nothing structurally.
    if (!rst) begin
      hd_rd   <= '0;
      hd_data <= '0;
      hd_eq   <= 1'b0;
      tl_rd   <= '0;
      tl_data <= '0;
      tl_eq   <= 1'b0;
    end else begin
      if (load_hd_in) begin
        hd_rd   <= bus.in_rd;
        hd_data <= conv_data;
        hd_eq   <= bus.in_eq;
      end else if (load_hd_tl) begin
        hd_rd   <= tl_rd;
        hd_data <= tl_data;
        hd_eq   <= tl_eq;
      end
      if (load_tl) begin
        tl_rd   <= bus.in_rd;
        tl_data <= conv_data;
        tl_eq   <= bus.in_eq;
      end
    end
  end

  // Retire bookkeeping: zero flag and wrapping retired-operation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zf      <= 1'b0;
      retired <= '0;
    end else if (pop) begin
      zf      <= hd_eq;
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_diff_writeback.sv
// Directed bench for diff_writeback. Inputs change and outputs are sampled
// on the falling edge, half a period away from the active rising edge.
module tb_diff_writeback;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              zf;
  logic              byp_valid;
  logic [ADDR_W-1:0] byp_addr;
  logic [31:0]       byp_data;
  logic [CNT_W-1:0]  retired;

  int n_checks;
  int n_fail;

  diff_writeback_if #(.ADDR_W(ADDR_W)) bus ();

  diff_writeback #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .zf       (zf),
    .byp_valid(byp_valid),
    .byp_addr (byp_addr),
    .byp_data (byp_data),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [5:0] diff, input logic eq,
                       input logic [ADDR_W-1:0] rd);
    bus.in_valid = v;
    bus.in_diff  = diff;
    bus.in_eq    = eq;
    bus.in_rd    = rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.wr_ready = 1'b0;
    drive(1'b0, 6'd0, 1'b0, '0);

    // Reset state
    step(); step();
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_wr_valid",  32'(bus.wr_valid), 32'd0);
    check("rst_wr_addr",   32'(bus.wr_addr),  32'd0);
    check("rst_wr_data",   bus.wr_data,       32'd0);
    check("rst_zf",        32'(zf),           32'd0);
    check("rst_byp_valid", 32'(byp_valid),    32'd0);
    check("rst_byp_addr",  32'(byp_addr),     32'd0);
    check("rst_byp_data",  byp_data,          32'd0);
    check("rst_retired",   32'(retired),      32'd0);
    rst = 1'b1;

    // Single result: diff=5, rd=3
    step();
    bus.wr_ready = 1'b1;
    drive(1'b1, 6'd5, 1'b0, 5'd3);
    step();
    drive(1'b0, 6'd0, 1'b0, '0);
    check("single_wr_valid",  32'(bus.wr_valid), 32'd1);
    check("single_wr_addr",   32'(bus.wr_addr),  32'd3);
    check("single_wr_data",   bus.wr_data,       32'h5);
    check("single_byp_valid", 32'(byp_valid),    32'd1);
    check("single_byp_addr",  32'(byp_addr),     32'd3);
    check("single_byp_data",  byp_data,          32'h5);
    step();
    check("single_zf",        32'(zf),           32'd0);
    check("single_retired",   32'(retired),      32'd1);
    check("single_idle",      32'(bus.wr_valid), 32'd0);
    check("single_hold_addr", 32'(bus.wr_addr),  32'd3);
    check("single_hold_data", bus.wr_data,       32'h5);

    // Equal operands: rd=7
    drive(1'b1, 6'd12, 1'b1, 5'd7);
    step();
    drive(1'b0, 6'd0, 1'b0, '0);
    check("eq_wr_addr", 32'(bus.wr_addr), 32'd7);
    check("eq_wr_data", bus.wr_data,      32'hFFFF_FFFF);
    step();
    check("eq_zf",      32'(zf),          32'd1);
    check("eq_retired", 32'(retired),     32'd2);

    // Backpressure: push rd=1,2,4 with wr_ready low
    bus.wr_ready = 1'b0;
    drive(1'b1, 6'd10, 1'b0, 5'd1);
    step();
    check("bp_ready_after1", 32'(bus.in_ready), 32'd1);
    check("bp_addr_a",       32'(bus.wr_addr),  32'd1);
    drive(1'b1, 6'd20, 1'b0, 5'd2);
    step();
    check("bp_ready_after2", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 6'd4, 1'b0, 5'd4);
    step();
    check("bp_ready_held",   32'(bus.in_ready), 32'd0);
    check("bp_valid_held",   32'(bus.wr_valid), 32'd1);
    check("bp_addr_held",    32'(bus.wr_addr),  32'd1);
    check("bp_data_held",    bus.wr_data,       32'd10);
    check("bp_retired_held", 32'(retired),      32'd2);
    bus.wr_ready = 1'b1;
    step();
    check("bp_out2_addr",    32'(bus.wr_addr),  32'd2);
    check("bp_out2_data",    bus.wr_data,       32'd20);
    check("bp_out2_retired", 32'(retired),      32'd3);
    check("bp_ready_back",   32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 6'd0, 1'b0, '0);
    check("bp_out3_addr",    32'(bus.wr_addr),  32'd4);
    check("bp_out3_data",    bus.wr_data,       32'd4);
    check("bp_out3_retired", 32'(retired),      32'd4);
    step();
    check("bp_done_valid",   32'(bus.wr_valid), 32'd0);
    check("bp_done_retired", 32'(retired),      32'd5);
    check("bp_done_zf",      32'(zf),           32'd0);

    // r0 discard followed by rd=9
    drive(1'b1, 6'd0, 1'b1, 5'd0);
    step();
    check("r0_no_write", 32'(bus.wr_valid), 32'd0);
    check("r0_no_byp",   32'(byp_valid),    32'd0);
    drive(1'b1, 6'd2, 1'b0, 5'd9);
    step();
    drive(1'b0, 6'd0, 1'b0, '0);
    check("r0_zf",       32'(zf),           32'd1);
    check("r0_retired",  32'(retired),      32'd6);
    check("r9_valid",    32'(bus.wr_valid), 32'd1);
    check("r9_addr",     32'(bus.wr_addr),  32'd9);
    check("r9_data",     bus.wr_data,       32'd2);
    step();
    check("r9_retired",  32'(retired),      32'd7);
    check("r9_zf",       32'(zf),           32'd0);

    // Saturation of out-of-range diff values
    bus.wr_ready = 1'b0;
    drive(1'b1, 6'd40, 1'b0, 5'd5);
    step();
    check("sat40_data", bus.wr_data, 32'd31);
    drive(1'b1, 6'd32, 1'b0, 5'd6);
    step();
    drive(1'b0, 6'd0, 1'b0, '0);
    bus.wr_ready = 1'b1;
    step();
    check("sat32_addr", 32'(bus.wr_addr), 32'd6);
    check("sat32_data", bus.wr_data,      32'd31);
    step();
    check("sat_retired", 32'(retired), 32'd9);

    // Counter wrap: stream 65526 r0 results to reach 16'hFFFF
    drive(1'b1, 6'd1, 1'b0, 5'd0);
    for (int i = 0; i < 65526; i++) step();
    drive(1'b0, 6'd0, 1'b0, '0);
    step();
    check("wrap_max",    32'(retired), 32'hFFFF);
    check("wrap_max_zf", 32'(zf),      32'd0);
    drive(1'b1, 6'd0, 1'b1, 5'd0);
    step();
    drive(1'b0, 6'd0, 1'b0, '0);
    step();
    check("wrap_zero",    32'(retired), 32'd0);
    check("wrap_zero_zf", 32'(zf),      32'd1);

    // Mid-stream asynchronous reset with two entries buffered
    bus.wr_ready = 1'b0;
    drive(1'b1, 6'd0, 1'b1, 5'd1);
    step();
    drive(1'b1, 6'd3, 1'b0, 5'd2);
    step();
    drive(1'b0, 6'd0, 1'b0, '0);
    step();
    check("mid_full_ready", 32'(bus.in_ready), 32'd0);
    check("mid_full_addr",  32'(bus.wr_addr),  32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("mid_rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    check("mid_rst_zf",       32'(zf),           32'd0);
    check("mid_rst_retired",  32'(retired),      32'd0);
    check("mid_rst_byp",      32'(byp_valid),    32'd0);
    #1 rst = 1'b1;
    step();
    bus.wr_ready = 1'b1;
    drive(1'b1, 6'd1, 1'b0, 5'd3);
    step();
    drive(1'b0, 6'd0, 1'b0, '0);
    check("post_rst_addr", 32'(bus.wr_addr), 32'd3);
    check("post_rst_data", bus.wr_data,      32'd1);
    step();
    check("post_rst_retired", 32'(retired),      32'd1);
    check("post_rst_empty",   32'(bus.wr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
